// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg
// Shared definitions for the uart_tx arbiter slice:
//   - state_t      : arbiter FSM encoding (IDLE=0, LOAD=1, START=2, WAIT_DONE=3)
//   - DW_DEFAULT   : default data width, must match uart_tx
//   - N_DEFAULT    : default requester count
//   - CLK_HZ, BAUD, CLKS_PER_BIT : baud constants used with uart_tx
// Configuration macro: UART_TX_ARBITER_RR_EN (round-robin when defined,
// fixed lowest-index priority otherwise).
package uart_tx_arbiter_pkg;

    localparam int DW_DEFAULT   = 8;
    localparam int N_DEFAULT    = 4;

    localparam int CLK_HZ       = 50_000_000;
    localparam int BAUD         = 115_200;
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        START     = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
// Bundles the requester side and the uart_tx side of the arbiter.
//   req      : level request per requester
//   data     : flattened requester bytes, requester i at [i*DW +: DW]
//   ack      : one-cycle capture pulse per requester
//   grant    : one-hot current owner of the transmitter
//   busy     : arbiter not idle
//   tx_start : start strobe to uart_tx
//   tx_data  : registered byte to uart_tx
//   tx_ready : uart_tx idle / able to accept a byte
// Modports:
//   master : the arbiter itself
//   slave  : requesters plus transmitter (the environment)
interface uart_tx_arbiter_if
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int DW = DW_DEFAULT
) ();

    logic [N-1:0]    req;
    logic [N*DW-1:0] data;
    logic [N-1:0]    ack;
    logic [N-1:0]    grant;
    logic            busy;
    logic            tx_start;
    logic [DW-1:0]   tx_data;
    logic            tx_ready;

    modport master (
        input  req, data, tx_ready,
        output ack, grant, busy, tx_start, tx_data
    );

    modport slave (
        output req, data, tx_ready,
        input  ack, grant, busy, tx_start, tx_data
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// uart_tx_arbiter_rr_pick
// Combinational winner selection.
//   req : pending requests
//   ptr : search start index (only with UART_TX_ARBITER_RR_EN)
//   win : one-hot winner, zero when req is zero
// With UART_TX_ARBITER_RR_EN the search starts at ptr and wraps modulo N;
// without it the lowest set index wins.
module uart_tx_arbiter_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
`ifdef UART_TX_ARBITER_RR_EN
    input  logic [$clog2(N)-1:0] ptr,
`endif
    output logic [N-1:0]         win
);

`ifdef UART_TX_ARBITER_RR_EN
    always_comb begin
        logic found;
        int   idx;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`else
    always_comb begin
        logic found;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[k]) begin
                win[k] = 1'b1;
                found  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one uart_tx between N byte requesters. A winner is picked in IDLE,
// its byte is captured and acknowledged in LOAD, tx_start is held in START
// until the transmitter goes busy, and ownership is kept in WAIT_DONE until
// the transmitter reports ready again.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : uart_tx_arbiter_if.master (req/data/ack/grant/busy/tx_*)
// Configuration macro: UART_TX_ARBITER_RR_EN selects round-robin; default
// build is fixed priority (lowest index wins, no pointer).
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.master bus
);

    state_t        state, state_d;
    logic [N-1:0]  win, win_d;        // winner latched in IDLE, used in LOAD
    logic [N-1:0]  pick;
    logic [N-1:0]  ack_q, ack_d;
    logic [N-1:0]  grant_q, grant_d;
    logic          tx_start_q, tx_start_d;
    logic [DW-1:0] tx_data_q, tx_data_d;

`ifdef UART_TX_ARBITER_RR_EN
    localparam int PW = $clog2(N);
    logic [PW-1:0] ptr, ptr_d;

    uart_tx_arbiter_rr_pick #(.N(N)) u_pick (
        .req (bus.req),
        .ptr (ptr),
        .win (pick)
    );
`else
    uart_tx_arbiter_rr_pick #(.N(N)) u_pick (
        .req (bus.req),
        .win (pick)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            win        <= '0;
            ack_q      <= '0;
            grant_q    <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
`ifdef UART_TX_ARBITER_RR_EN
            ptr        <= '0;
`endif
        end else begin
            state      <= state_d;
            win        <= win_d;
            ack_q      <= ack_d;
            grant_q    <= grant_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
`ifdef UART_TX_ARBITER_RR_EN
            ptr        <= ptr_d;
`endif
        end
    end

    always_comb begin
        state_d    = state;
        win_d      = win;
        ack_d      = '0;              // ack is a single-cycle pulse
        grant_d    = grant_q;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;       // holds after the frame until next LOAD
`ifdef UART_TX_ARBITER_RR_EN
        ptr_d      = ptr;
`endif
        case (state)
            IDLE: begin
                // Requests are only looked at here; a busy transmitter blocks
                // arbitration entirely.
                if ((|bus.req) && bus.tx_ready) begin
                    win_d   = pick;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                grant_d = win;
                ack_d   = win;
                for (int i = 0; i < N; i++) begin
                    if (win[i]) begin
                        tx_data_d = bus.data[i*DW +: DW];
`ifdef UART_TX_ARBITER_RR_EN
                        ptr_d = (i == N - 1) ? '0 : PW'(i + 1);
`endif
                    end
                end
                state_d = START;
            end
            START: begin
                // tx_start must have been seen high for a cycle before a low
                // tx_ready counts as the transmitter accepting the byte.
                if (tx_start_q && !bus.tx_ready) begin
                    tx_start_d = 1'b0;
                    state_d    = WAIT_DONE;
                end else begin
                    tx_start_d = 1'b1;
                end
            end
            WAIT_DONE: begin
                tx_start_d = 1'b0;
                if (bus.tx_ready) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ack      = ack_q;
    assign bus.grant    = grant_q;
    assign bus.busy     = (state != IDLE);
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;

endmodule
